// File: rtl/dice_game_ctrl_p.sv
// Craps-style game controller: two free-running dice while the roll button is held,
// first-roll and point-roll evaluation, and saturating win/loss statistics.
module dice_game_ctrl_p #(
    parameter int SIDES = 6,
    parameter int CNT_W = 8,
    localparam int DW = $clog2(SIDES + 1),
    localparam int SW = DW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rb,
    input  logic             new_game,
    input  logic             clr_stats,
    output logic             roll,
    output logic             win,
    output logic             lose,
    output logic [DW-1:0]    die1,
    output logic [DW-1:0]    die2,
    output logic [SW-1:0]    sum,
    output logic [SW-1:0]    point,
    output logic             point_valid,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_ROLL1, S_EVAL1, S_POINT, S_ROLLN, S_EVALN, S_WIN, S_LOSE
    } state_t;

    localparam logic [SW-1:0] WA      = SW'(SIDES + 1);
    localparam logic [SW-1:0] WB      = SW'(2 * SIDES - 1);
    localparam logic [SW-1:0] CRAPS_H = SW'(2 * SIDES);
    localparam logic [DW-1:0] TOP     = DW'(SIDES);
    localparam logic [DW-1:0] ONE     = DW'(1);

    state_t state, state_next;
    logic   spinning, advance, leaving;
    logic   first_win, first_lose, enter_win, enter_lose;

    assign spinning   = (state == S_ROLL1) || (state == S_ROLLN);
    assign advance    = spinning && rb;
    assign leaving    = spinning && !rb;
    assign first_win  = (sum == WA) || (sum == WB);
    assign first_lose = (sum == SW'(2)) || (sum == SW'(3)) || (sum == CRAPS_H);
    assign enter_win  = (state_next == S_WIN)  && (state != S_WIN);
    assign enter_lose = (state_next == S_LOSE) && (state != S_LOSE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (rb) state_next = S_ROLL1;
            S_ROLL1: if (!rb) state_next = S_EVAL1;
            S_EVAL1: begin
                if (first_win)       state_next = S_WIN;
                else if (first_lose) state_next = S_LOSE;
                else                 state_next = S_POINT;
            end
            S_POINT: if (rb) state_next = S_ROLLN;
            S_ROLLN: if (!rb) state_next = S_EVALN;
            S_EVALN: begin
                // point can never equal WA, so the two tests are disjoint
                if (sum == point)    state_next = S_WIN;
                else if (sum == WA)  state_next = S_LOSE;
                else                 state_next = S_POINT;
            end
            S_WIN, S_LOSE: if (new_game) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        roll      = advance;
        win       = (state == S_WIN);
        lose      = (state == S_LOSE);
        state_dbg = state;
    end

    // die2 only steps in the cycle die1 wraps, so the pair counts through all SIDES^2 combinations
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            die1 <= ONE;
            die2 <= ONE;
        end else if (advance) begin
            if (die1 == TOP) begin
                die1 <= ONE;
                die2 <= (die2 == TOP) ? ONE : die2 + ONE;
            end else begin
                die1 <= die1 + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        sum <= SW'(2);
        else if (leaving) sum <= {1'b0, die1} + {1'b0, die2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            point       <= '0;
            point_valid <= 1'b0;
        end else if (state == S_EVAL1 && !first_win && !first_lose) begin
            point       <= sum;
            point_valid <= 1'b1;
        end else if ((state == S_WIN || state == S_LOSE) && new_game) begin
            point       <= '0;
            point_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt  <= '0;
            loss_cnt <= '0;
        end else if (clr_stats) begin
            win_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            if (enter_win && win_cnt != '1)   win_cnt  <= win_cnt + 1'b1;
            if (enter_lose && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
        end
    end

endmodule
